// File: rtl/insn_fetch_queue.sv
// ----------------------------------------------------------------------------
// insn_fetch_queue
//
// Instruction fetch stage of the RV32I core. It owns the fetch PC and issues
// sequential word reads to an instruction memory with a fixed 1-cycle read
// latency. Each returned word is buffered in a small prefetch FIFO together
// with its PC. A PC redirect from branch/jump resolution flushes the FIFO,
// drops any read still in flight and restarts fetch at the new PC.
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 2)
//   RESET_PC     fetch PC after reset
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high reset
//   imem_req     read request this cycle
//   imem_addr    word-aligned byte address of the request
//   imem_rdata   read data, valid exactly one cycle after a request
//   insn_valid   FIFO head is valid
//   insn         instruction at the FIFO head
//   insn_pc      PC of the head instruction
//   insn_ready   decode consumes the head this cycle
//   redirect     flush and restart fetch
//   redirect_pc  new fetch PC
//   misalign_err misaligned redirect flag (constant 0 in the default build)
//
// Build option
//   FETCH_MISALIGN_TRAP_EN  when defined, a redirect to a PC with non-zero
//                           low bits raises misalign_err and halts fetch
//                           until the next aligned redirect or reset. When
//                           undefined, the low two PC bits are ignored.
// ----------------------------------------------------------------------------
module insn_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        insn_valid,
   output logic [31:0] insn,
   output logic [31:0] insn_pc,
   input  logic        insn_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        misalign_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   // One extra bit so count + inflight can never wrap in the compare.
   localparam int OCC_W = CNT_W + 1;

   // State registers and their next-state values.
   logic [31:0]      fetch_pc_q,    fetch_pc_d;
   logic [CNT_W-1:0] count_q,       count_d;
   logic             inflight_q,    inflight_d;
   logic [31:0]      inflight_pc_q, inflight_pc_d;
   logic [PTR_W-1:0] head_q,        head_d;
   logic [PTR_W-1:0] tail_q,        tail_d;

   // FIFO storage: instruction word and its PC per entry.
   logic [31:0] fifo_insn_q [DEPTH];
   logic [31:0] fifo_pc_q   [DEPTH];

   logic        halted;
   logic        push;
   logic        pop;
   logic [31:0] redirect_target;
   logic [OCC_W-1:0] occupancy;

   // Masking (rather than slicing) keeps every bit of redirect_pc in use
   // even in the build where the low bits carry no meaning.
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic halted_q,       halted_d;
   logic misalign_err_q, misalign_err_d;
   logic redirect_misaligned;

   assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
   assign halted              = halted_q;
   assign misalign_err        = !reset && misalign_err_q;

   always_comb begin
      halted_d       = halted_q;
      misalign_err_d = misalign_err_q;
      // Both flags are sticky until the next redirect decides them again.
      if (redirect) begin
         halted_d       = redirect_misaligned;
         misalign_err_d = redirect_misaligned;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         halted_q       <= 1'b0;
         misalign_err_q <= 1'b0;
      end else begin
         halted_q       <= halted_d;
         misalign_err_q <= misalign_err_d;
      end
   end
`else
   assign halted       = 1'b0;
   assign misalign_err = 1'b0;
`endif

   // Every in-flight read already owns a FIFO slot, so the FIFO can never
   // overflow. A same-cycle pop is deliberately not credited here.
   assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q);
   assign imem_req  = !reset && !redirect && !halted && (occupancy < OCC_W'(DEPTH));
   assign imem_addr = fetch_pc_q;

   // Outputs are forced low during reset even if the FIFO still holds data.
   assign insn_valid = !reset && (count_q != '0);
   assign insn       = fifo_insn_q[head_q];
   assign insn_pc    = fifo_pc_q[head_q];

   // The read returning this cycle is stale when a redirect is in progress.
   assign push = inflight_q && !redirect;
   assign pop  = insn_valid && insn_ready;

   // NOTE: every variable gets a default at the top of the block so that no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      count_d       = count_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      head_d        = head_q;
      tail_d        = tail_q;

      if (imem_req) begin
         fetch_pc_d    = fetch_pc_q + 32'd4;
         inflight_d    = 1'b1;
         inflight_pc_d = fetch_pc_q;
      end

      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
      if (push) begin
         tail_d = tail_q + PTR_W'(1);
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Redirect overrides everything above; a same-cycle pop still counts
      // as consumed by decode, but the FIFO is emptied regardless.
      if (redirect) begin
         fetch_pc_d = redirect_target;
         count_d    = '0;
         inflight_d = 1'b0;
         head_d     = '0;
         tail_d     = '0;
      end
   end

   // NOTE: sequential state is written with non-blocking assignments so all
   // registers update together from values sampled before the clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         count_q       <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         head_q        <= '0;
         tail_q        <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
      end
   end

   // NOTE: the FIFO storage is not reset; count_q gates insn_valid, so stale
   // contents are never observed and the array can map to plain flops/RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_insn_q[tail_q] <= imem_rdata;
         fifo_pc_q[tail_q]   <= inflight_pc_q;
      end
   end

endmodule

// File: tb/tb_insn_fetch_queue.sv
module tb_insn_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        insn_valid;
   logic [31:0] insn;
   logic [31:0] insn_pc;
   logic        insn_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        misalign_err;

   insn_fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .insn_valid   (insn_valid),
      .insn         (insn),
      .insn_pc      (insn_pc),
      .insn_ready   (insn_ready),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .misalign_err (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: mem[k] = 32'h1000_0000 + k, one-cycle read latency.
   logic [31:0] resp_addr;
   always @(posedge clk) resp_addr <= imem_addr;
   assign imem_rdata = 32'h1000_0000 + (resp_addr >> 2);

   // Scoreboard entry: expected PC and the cycle its request was issued.
   typedef struct {
      logic [31:0] pc;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          cyc;
   logic [31:0] m_pc;
   logic        m_halt;
   logic        m_err;
   int          dut_req_cnt;
   int          total;
   int          bad;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Called at a falling edge with this cycle's inputs already driven.
   // Checks the outputs, advances the model across the next rising edge.
   task automatic step();
      exp_t e;
      logic exp_valid;
      logic exp_req;
      #1;
      if (imem_req === 1'b1) dut_req_cnt++;
      if (reset) begin
         check("rst_req",   imem_req,     0);
         check("rst_valid", insn_valid,   0);
         check("rst_err",   misalign_err, 0);
         sb.delete();
         m_pc   = RESET_PC;
         m_halt = 1'b0;
         m_err  = 1'b0;
      end else begin
         exp_valid = 1'b0;
         if (sb.size() > 0) exp_valid = (cyc >= sb[0].cyc + 2);
         exp_req = !redirect && !m_halt && (sb.size() < DEPTH);
         check("valid", insn_valid,   exp_valid);
         check("req",   imem_req,     exp_req);
         check("err",   misalign_err, m_err);
         if (exp_valid && insn_ready) begin
            e = sb.pop_front();
            check("insn_pc", insn_pc, e.pc);
            check("insn",    insn,    32'h1000_0000 + (e.pc >> 2));
         end
         if (redirect) begin
            sb.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
            m_halt = (redirect_pc[1:0] != 2'b00);
            m_err  = (redirect_pc[1:0] != 2'b00);
`endif
         end else if (exp_req) begin
            check("req_addr", imem_addr, m_pc);
            sb.push_back('{pc: m_pc, cyc: cyc});
            m_pc = m_pc + 32'd4;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      cyc         = 0;
      dut_req_cnt = 0;
      m_pc        = RESET_PC;
      m_halt      = 1'b0;
      m_err       = 1'b0;
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      insn_ready  = 1'b0;
      @(negedge clk);   // first edge establishes a known state
      step();           // checked reset cycle

      // Streaming: one instruction per cycle from C2.
      reset       = 1'b0;
      insn_ready  = 1'b1;
      dut_req_cnt = 0;
      repeat (2) step();
      #1;
      check("stream_c2_insn", insn,    32'h1000_0000);
      check("stream_c2_pc",   insn_pc, 32'h0);
      repeat (12) step();
      check("stream_reqs", dut_req_cnt, 14);

      // Backpressure from reset: exactly four requests, then drain in order.
      reset = 1'b1;
      step();
      reset       = 1'b0;
      insn_ready  = 1'b0;
      dut_req_cnt = 0;
      repeat (8) step();
      check("bp_reqs", dut_req_cnt, 4);
      insn_ready = 1'b1;
      repeat (10) step();

      // Redirect with the FIFO filling and a read in flight.
      insn_ready = 1'b0;
      repeat (4) step();
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect   = 1'b0;
      insn_ready = 1'b1;
      repeat (2) step();
      #1;
      check("rd_valid_r3", insn_valid, 1);
      check("rd_pc_r3",    insn_pc,    32'h100);
      repeat (6) step();

      // Redirect coinciding with a pop.
      insn_ready = 1'b0;
      step();
      insn_ready  = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      step();
      redirect = 1'b0;
      repeat (2) step();
      #1;
      check("rp_pc", insn_pc, 32'h40);
      repeat (4) step();

      // Reset while the FIFO holds three entries.
      insn_ready  = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h80;
      step();
      redirect = 1'b0;
      repeat (4) step();
      reset = 1'b1;
      step();
      reset      = 1'b0;
      insn_ready = 1'b1;
      #1;
      check("post_rst_req",  imem_req,  1);
      check("post_rst_addr", imem_addr, RESET_PC);
      repeat (6) step();

      // Misaligned redirect.
      redirect    = 1'b1;
      redirect_pc = 32'h102;
      step();
      redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      dut_req_cnt = 0;
      repeat (4) step();
      check("halt_reqs", dut_req_cnt, 0);
      #1;
      check("halt_err", misalign_err, 1);
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      #1;
      check("resume_err",  misalign_err, 0);
      check("resume_addr", imem_addr,    32'h200);
      repeat (6) step();
`else
      #1;
      check("mis_addr", imem_addr, 32'h100);
      repeat (6) step();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/insn_fetch_queue.md
# insn_fetch_queue

Instruction fetch stage of the RV32I core, sitting between the instruction memory and the decode stage. It owns the fetch PC, issues sequential word reads to a fixed 1-cycle-latency instruction memory, and buffers returned words with their PCs in a small prefetch FIFO. It also accepts PC redirects from branch and jump resolution and discards stale entries and in-flight reads.

## Interface
- `DEPTH`, 4: FIFO entries. Power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `imem_req` output 1: read request this cycle.
- `imem_addr` output 32: byte address of the request, word aligned.
- `imem_rdata` input 32: read data, valid exactly one cycle after a request.
- `insn_valid` output 1: FIFO head is valid.
- `insn` output 32: instruction at FIFO head.
- `insn_pc` output 32: PC of the head instruction.
- `insn_ready` input 1: decode consumes the head this cycle.
- `redirect` input 1: flush and restart fetch.
- `redirect_pc` input 32: new fetch PC.
- `misalign_err` output 1: misaligned redirect flag. Tied to 0 unless the macro is defined.

## Operation
- State:
  - `fetch_pc`, 32 bits.
  - `count`, 0..DEPTH.
  - `inflight`, 1 bit, with `inflight_pc`.
  - head and tail pointers, log2(DEPTH) bits, wrapping modulo DEPTH.
- Issue:
  - `imem_req = !reset && !redirect && !halted && (count + inflight < DEPTH)`.
  - `imem_addr = fetch_pc` (combinational).
  - On issue: `fetch_pc += 4` (wraps modulo 2^32), `inflight <= 1`, `inflight_pc <= fetch_pc`.
  - Otherwise `inflight <= 0`.
- Push: when `inflight` is set and there is no redirect, write `{imem_rdata, inflight_pc}` at the tail.
- Pop: when `insn_valid && insn_ready`, advance the head.
- Push and pop in the same cycle: `count` is unchanged.
- Output: `insn_valid = (count != 0)`. `insn` and `insn_pc` are driven combinationally from the head entry.
- Overflow is impossible by construction: the issue rule reserves a slot for every in-flight read. The issue rule does not credit a same-cycle pop.
- Redirect has priority over every other event in the same cycle:
  - `count <= 0` and both pointers are reset.
  - `inflight <= 0`, so the response arriving next cycle is dropped.
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - No request is issued in the redirect cycle.
  - A pop in the same cycle counts as consumed by decode; the FIFO is cleared regardless.
- Reset, synchronous, any time (including mid-fill or mid-redirect): `fetch_pc = RESET_PC`, `count = 0`, `inflight = 0`, pointers 0, `misalign_err = 0`.
  - Outputs during reset: `imem_req = 0`, `insn_valid = 0`, `misalign_err = 0`.
  - A response arriving in the first cycle after reset is dropped.

## Timing
- Let C0 be the first cycle with `reset` low: `imem_req = 1`, `imem_addr = RESET_PC`.
  - C1: data is returned and written.
  - C2: `insn_valid = 1`.
- Fetch-to-decode latency: 2 cycles.
- Sustained throughput with `insn_ready` held at 1: one instruction per cycle.
- Redirect in cycle R:
  - `insn_valid = 0` in R+1.
  - Request at `redirect_pc` in R+1.
  - `insn_valid = 1` in R+3.
- With `insn_ready` held at 0 from reset:
  - Requests are issued in C0–C3.
  - `imem_req = 0` from C4 onward.
  - FIFO is full (`count = 4`) from the end of C4.

## Configuration
- Macro: `FETCH_MISALIGN_TRAP_EN`.
- Defined:
  - A redirect with `redirect_pc[1:0] != 0` sets `misalign_err <= 1` and `halted <= 1`.
  - While halted, no requests are issued.
  - Both flags are sticky until the next aligned redirect or reset.
- Undefined:
  - `redirect_pc[1:0]` is ignored (forced to 0).
  - `misalign_err` is constant 0.
  - `halted` does not exist.

## Test plan
- Streaming:
  - Stimulus: `mem[k] = 32'h1000_0000 + k`, `insn_ready = 1` from reset.
  - Required: C2 shows `insn = 32'h1000_0000`, `insn_pc = 0`. One instruction per cycle follows, with `insn_pc` 4, 8, 12, …
- Backpressure:
  - Stimulus: `insn_ready = 0` from reset.
  - Required: exactly 4 requests (addresses 0, 4, 8, 12). Then `ready = 1` drains them in order, and requests resume at address 16.
- Redirect with full FIFO and a read in flight:
  - Stimulus: `redirect = 1`, `redirect_pc = 32'h100`.
  - Required: `insn_valid = 0` next cycle. The stale word is never presented. The first `insn_pc` after the redirect is `32'h100`, 3 cycles after the redirect.
- Simultaneous redirect and pop:
  - Stimulus: `count = 2`, `insn_ready = 1`, `redirect` to `32'h40`.
  - Required: the FIFO is empty next cycle, and the next instruction presented has `insn_pc = 32'h40`.
- Reset mid-operation:
  - Stimulus: assert `reset` for 1 cycle while `count = 3`.
  - Required: `insn_valid = 0` and `imem_req = 0` during reset, then the first request after reset is at `RESET_PC`.
- Macro defined:
  - Stimulus: redirect to `32'h102`.
  - Required: `misalign_err = 1` and no requests. A subsequent redirect to `32'h200` clears `misalign_err`, and fetch resumes at `32'h200`.
- Macro undefined:
  - Stimulus: redirect to `32'h102`.
  - Required: the next request address is `32'h100`.
